// File: rtl/mem_master.sv
// Initiator for the word-wide data-memory port: sizing, lane alignment, load extension, range check.
// Define MEM_MISALIGN_SPLIT_EN to allow misaligned accesses, split into two word cycles when crossing.
module mem_master #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h00001000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wen,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata
);

    // Request handshake: a request transfers on a rising edge where req_valid && req_ready.
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t state, state_nxt;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic        err_q;
    logic        cross_q;
    logic [7:0]  lanes_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] result_q;

    logic [2:0]        req_bytes;
    logic [3:0]        req_mask;
    logic [ADDR_W:0]   req_last;
    logic              req_bad;
    logic              req_cross;
    logic [7:0]        req_lanes;
    logic [63:0]       req_wide;
    logic [2:0]        hi_sh;
    logic [31:0]       rd_lo;
    logic [31:0]       rd_hi;
    logic [31:0]       ext;

    always_comb begin
        req_bytes = 3'd1;
        req_mask  = 4'b0001;
        case (req_size)
            2'b01: begin
                req_bytes = 3'd2;
                req_mask  = 4'b0011;
            end
            2'b10: begin
                req_bytes = 3'd4;
                req_mask  = 4'b1111;
            end
            default: begin
                req_bytes = 3'd1;
                req_mask  = 4'b0001;
            end
        endcase
        // Last byte computed one bit wider so that a wrap past the top is still caught.
        req_last = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, req_bytes} - {{ADDR_W{1'b0}}, 1'b1};
        req_bad  = (req_size == 2'b11) || (req_last >= {1'b0, ADDR_LIMIT});
`ifndef MEM_MISALIGN_SPLIT_EN
        req_bad  = req_bad || ((req_size == 2'b01) && req_addr[0])
                           || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
        req_cross = (({1'b0, req_addr[1:0]} + req_bytes) > 3'd4);
        req_lanes = {4'b0000, req_mask} << req_addr[1:0];
        req_wide  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    always_comb begin
        hi_sh = 3'd4 - {1'b0, off_q};
        rd_lo = mem_rdata >> {off_q, 3'b000};
        rd_hi = mem_rdata << {hi_sh, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{~uns_q & result_q[7]}}, result_q[7:0]};
            2'b01:   ext = {{16{~uns_q & result_q[15]}}, result_q[15:0]};
            default: ext = result_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        mem_wen   = 4'hF;
        mem_rd    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? RESP : ACC1;
            end
            ACC1: begin
                // Without split support a legal request never crosses, so ACC2 stays unreachable.
                state_nxt = cross_q ? ACC2 : RESP;
                mem_rd    = ~we_q;
                if (we_q) mem_wen = ~lanes_q[3:0];
            end
            ACC2: begin
                state_nxt = RESP;
                mem_rd    = ~we_q;
                if (we_q) mem_wen = ~lanes_q[7:4];
            end
            RESP: begin
                state_nxt = IDLE;
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q) rsp_rdata = ext;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            err_q      <= 1'b0;
            cross_q    <= 1'b0;
            lanes_q    <= 8'h00;
            wdata_hi_q <= 32'h0;
            result_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q       <= req_we;
                    size_q     <= req_size;
                    uns_q      <= req_unsigned;
                    off_q      <= req_addr[1:0];
                    err_q      <= req_bad;
                    cross_q    <= req_cross;
                    lanes_q    <= req_lanes;
                    wdata_hi_q <= req_wide[63:32];
                    result_q   <= 32'h0;
                    if (!req_bad) begin
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_we) mem_wdata <= req_wide[31:0];
                    end
                end
                ACC1: begin
                    if (!we_q) result_q <= rd_lo;
                    if (cross_q) begin
                        mem_addr <= mem_addr + ADDR_W'(4);
                        if (we_q) mem_wdata <= wdata_hi_q;
                    end
                end
                ACC2: if (!we_q) result_q <= result_q | rd_hi;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: vector table of load/store requests plus crossing and reset sequences.
// Build with MEM_MISALIGN_SPLIT_EN defined to exercise the split-access expectations.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wen;
    logic        mem_rd;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] tb_mem [0:1023];

    mem_master #(.ADDR_W(32), .ADDR_LIMIT(32'h00001000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, byte-lane write on the rising edge.
    assign mem_rdata = tb_mem[mem_addr[11:2]];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (!mem_wen[k]) tb_mem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_wen;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic e, int lat, logic [3:0] wen,
                                logic [31:0] maddr, logic [31:0] mwd);
        vec_t v;
        v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = rd; v.exp_err = e; v.exp_lat = lat; v.exp_wen = wen;
        v.exp_maddr = maddr; v.exp_wdata = mwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        logic        got;
        logic        first;
        logic        saw_mem;
        logic [3:0]  wen1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        rd1;
        logic        err_s;
        logic [31:0] rdata_s;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; got = 1'b0; first = 1'b1; saw_mem = 1'b0;
        wen1 = 4'hF; addr1 = 32'h0; wdata1 = 32'h0; rd1 = 1'b0; err_s = 1'b0; rdata_s = 32'h0;
        while (!got && lat < 8) begin
            if (rsp_valid) begin
                got = 1'b1;
                err_s = rsp_err;
                rdata_s = rsp_rdata;
            end else begin
                if (first) begin
                    wen1 = mem_wen; addr1 = mem_addr; wdata1 = mem_wdata; rd1 = mem_rd;
                    first = 1'b0;
                end
                if (mem_rd || mem_wen != 4'hF) saw_mem = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d err", idx), err_s, v.exp_err);
        check($sformatf("v%0d rdata", idx), rdata_s, v.exp_rdata);
        if (v.exp_err) begin
            check($sformatf("v%0d no_mem_cycle", idx), saw_mem, 1'b0);
        end else begin
            check($sformatf("v%0d acc1_addr", idx), addr1, v.exp_maddr);
            check($sformatf("v%0d acc1_wen", idx), wen1, v.exp_wen);
            check($sformatf("v%0d acc1_rd", idx), rd1, !v.we);
            if (v.we) check($sformatf("v%0d acc1_wdata", idx), wdata1, v.exp_wdata);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d pulse_end", idx), rsp_valid, 1'b0);
        check($sformatf("v%0d ready_back", idx), req_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", req_ready, 1'b1);
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", rsp_err, 1'b0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_wen", mem_wen, 4'hF);
        check("rst mem_rd", mem_rd, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //               we  sz     u     addr          wdata         rdata         err lat wen    maddr         mwdata
        tbl.push_back(mk(1, 2'b10, 0, 32'h000003FC, 32'h12345678, 32'h0,        0, 2, 4'h0, 32'h000003FC, 32'h12345678));
        tbl.push_back(mk(0, 2'b10, 0, 32'h000003FC, 32'h0,        32'h12345678, 0, 2, 4'hF, 32'h000003FC, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h00000100, 32'h80017FFF, 32'h0,        0, 2, 4'h0, 32'h00000100, 32'h80017FFF));
        tbl.push_back(mk(0, 2'b01, 0, 32'h00000102, 32'h0,        32'hFFFF8001, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h00000102, 32'h0,        32'h00008001, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h00000101, 32'h000000AB, 32'h0,        0, 2, 4'hD, 32'h00000100, 32'h0000AB00));
        tbl.push_back(mk(0, 2'b00, 0, 32'h00000101, 32'h0,        32'hFFFFFFAB, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h00000101, 32'h0,        32'h000000AB, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h00000100, 32'h0,        32'hFFFFABFF, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h00000FFC, 32'hCAFEF00D, 32'h0,        0, 2, 4'h0, 32'h00000FFC, 32'hCAFEF00D));
        tbl.push_back(mk(0, 2'b10, 0, 32'h00000FFC, 32'h0,        32'hCAFEF00D, 0, 2, 4'hF, 32'h00000FFC, 32'h0));
        tbl.push_back(mk(0, 2'b00, 0, 32'h00000FFF, 32'h0,        32'hFFFFFFCA, 0, 2, 4'hF, 32'h00000FFC, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h00000FFF, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h00000FFE, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(0, 2'b11, 0, 32'h00000000, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h00001000, 32'h00000055, 32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h00000FFD, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h00000FFE, 32'h00001234, 32'h0,        0, 2, 4'h3, 32'h00000FFC, 32'h12340000));
        tbl.push_back(mk(0, 2'b10, 0, 32'h00000FFC, 32'h0,        32'h1234F00D, 0, 2, 4'hF, 32'h00000FFC, 32'h0));
`ifdef MEM_MISALIGN_SPLIT_EN
        tbl.push_back(mk(0, 2'b01, 0, 32'h00000101, 32'h0,        32'h000001AB, 0, 2, 4'hF, 32'h00000100, 32'h0));
        tbl.push_back(mk(0, 2'b10, 1, 32'h00000102, 32'h0,        32'h00008001, 0, 3, 4'hF, 32'h00000100, 32'h0));
`else
        tbl.push_back(mk(0, 2'b01, 0, 32'h00000101, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
        tbl.push_back(mk(0, 2'b10, 1, 32'h00000102, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
`endif
        tbl.push_back(mk(1, 2'b10, 0, 32'h000000FC, 32'h44332211, 32'h0,        0, 2, 4'h0, 32'h000000FC, 32'h44332211));
        tbl.push_back(mk(1, 2'b10, 0, 32'h00000100, 32'h88776655, 32'h0,        0, 2, 4'h0, 32'h00000100, 32'h88776655));
`ifdef MEM_MISALIGN_SPLIT_EN
        tbl.push_back(mk(0, 2'b10, 0, 32'h000000FE, 32'h0,        32'h66554433, 0, 3, 4'hF, 32'h000000FC, 32'h0));
`else
        tbl.push_back(mk(0, 2'b10, 0, 32'h000000FE, 32'h0,        32'h0,        1, 1, 4'hF, 32'h0,        32'h0));
`endif

        for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

        // Crossing load: second cycle must address the following word.
`ifdef MEM_MISALIGN_SPLIT_EN
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h000000FE; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("split ld acc1 addr", mem_addr, 32'h000000FC);
        @(posedge clk); #1;
        check("split ld acc2 addr", mem_addr, 32'h00000100);
        check("split ld acc2 rd", mem_rd, 1'b1);
        @(posedge clk); #1;
        check("split ld rsp", {rsp_valid, rsp_err}, 2'b10);
        check("split ld rdata", rsp_rdata, 32'h66554433);
        @(posedge clk); #1;
`endif

        // Reset in the middle of a store: the access is dropped and no response appears.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
        req_addr = 32'h000000FE; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("xst acc1 addr", mem_addr, 32'h000000FC);
        check("xst acc1 wen", mem_wen, 4'h3);
        check("xst acc1 wdata", mem_wdata, 32'hBEEF0000);
        @(posedge clk); #1;
        check("xst acc2 addr", mem_addr, 32'h00000100);
        check("xst acc2 wen", mem_wen, 4'hC);
        check("xst acc2 wdata", mem_wdata, 32'h0000DEAD);
`else
        req_addr = 32'h00000100; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("st acc1 addr", mem_addr, 32'h00000100);
        check("st acc1 wen", mem_wen, 4'h0);
        check("st acc1 wdata", mem_wdata, 32'hDEADBEEF);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort mem_wen", mem_wen, 4'hF);
        check("abort mem_rd", mem_rd, 1'b0);
        check("abort req_ready", req_ready, 1'b1);
        check("abort rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort quiet c%0d", c), {rsp_valid, mem_wen}, 5'b01111);
        end

        run_vec(100, mk(0, 2'b10, 0, 32'h000003FC, 32'h0, 32'h12345678, 0, 2, 4'hF, 32'h000003FC, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the core's word-wide data-memory interface.
- Accepts load/store requests from the core pipeline over a valid/ready handshake.
- Drives the memory port: word address, write data, active-low byte write enables, read strobe. The memory returns read data combinationally.
- Handles byte/half/word sizing, lane alignment, load sign/zero extension and address-range checking, then returns one response pulse per request.

Parameters:
- ADDR_W, 32, width of core and memory addresses.
- ADDR_LIMIT, 32'h00001000, first illegal byte address; memory occupies bytes 0..ADDR_LIMIT-1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; illegal size or out of range, plus misaligned when split is disabled
- mem_addr  out  ADDR_W  word-aligned byte address (low 2 bits always 0)
- mem_wdata  out  32  lane-positioned store data; byte k on bits 8k+7:8k
- mem_wen  out  4  active-low byte write enables; 4'hF when not storing
- mem_rd  out  1  read strobe
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- States: IDLE, ACC1, ACC2, RESP.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_wen=4'hF, mem_rd=0.
- Reset mid-transaction aborts it: no further memory cycle, no response.
- Accept: in IDLE, when req_valid=1 the request is registered at the clock edge.
  - Error if the request is illegal: size=11, or last byte (addr+bytes-1, computed in ADDR_W+1 bits, no wrap) >= ADDR_LIMIT.
  - Illegal request → RESP with rsp_err=1 and no memory cycle.
  - Legal request → ACC1.
- Offset o = addr[1:0]. A request "crosses" when o+bytes > 4.
- ACC1:
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Store: mem_wen lanes o..min(3,o+bytes-1) low; mem_wdata = req_wdata << 8*o.
  - Load: mem_rd=1; bytes o.. of mem_rdata are captured into the low bytes of the result at the edge.
  - Next state: ACC2 if crossing, else RESP.
- ACC2:
  - mem_addr = first word address + 4.
  - Store: lanes 0..(o+bytes-5) low; mem_wdata = req_wdata >> 8*(4-o).
  - Load: captured bytes fill the result above those from ACC1.
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Loads: rsp_rdata is the assembled value, sign- or zero-extended from bit 8*bytes-1.
  - Then → IDLE; req_ready rises the following cycle.
- Memory port outside ACC1/ACC2: mem_wen=4'hF, mem_rd=0; mem_addr and mem_wdata hold their last values.
- Latency: aligned or non-crossing request accepted at edge N gives rsp_valid during cycle N+2; crossing gives N+3; errors give N+1.
- req_valid while busy is ignored (req_ready=0). No request can be lost: the core holds req_valid until accepted.

Optional Feature:
- MEM_MISALIGN_SPLIT_EN defined: behaviour as above. Misaligned accesses are legal; crossing accesses split into ACC1+ACC2.
- Not defined:
  - Any access with addr not a multiple of its size (half with o odd, word with o≠0) is illegal and goes straight to RESP with rsp_err=1, no memory cycle.
  - ACC2 is unreachable.

Test Plan:
- Word store 0x12345678 @0x3FC, then word load @0x3FC → ACC1 has mem_wen=4'h0, mem_addr=0x3FC; load rsp_rdata=0x12345678, rsp_err=0, rsp_valid at accept+2.
- Byte store 0xAB @0x101 → mem_wen=4'b1101, mem_wdata[15:8]=0xAB. Signed byte load @0x101 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Half load @0x102 with word 0x80017FFF at 0x100 → signed 0xFFFF8001; unsigned 0x00008001.
- Word load @0x0FE with split enabled (0x100: 0x44332211 at 0x0FC, 0x88776655) → two cycles, addrs 0x0FC then 0x100, rsp_rdata=0x66554433 at accept+3. Split disabled → rsp_err=1 at accept+1, mem_rd never high.
- Word load @0xFFE, or size=11 → rsp_err=1, rsp_rdata=0, no memory cycle.
- rst asserted during ACC2 of a split store → next cycle mem_wen=4'hF, state IDLE, req_ready=1, no rsp_valid pulse.
